mux_sel_reg: RTL

- Parametrised, registered N:1 selector; the sequential successor to the 16-bit 2:1 combinational mux.
- Picks one of CHANNELS WIDTH-bit input channels and captures it into a single-entry output register behind a valid/ready handshake.
- Two selection modes: fixed select from the Sel port, or round-robin among valid channels.
- Used wherever the datapath merges multiple producers (e.g. writeback sources, memory-request sources) into one registered stage.

---
 rtl/mux_sel_reg.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mux_sel_reg.sv
// Registered N:1 channel selector with a valid/ready handshake on both sides.
// Selection is either fixed through Sel (MODE=0) or round-robin over the valid channels (MODE=1).
module mux_sel_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] In,
  input  logic [CHANNELS-1:0]       InValid,
  output logic [CHANNELS-1:0]       InReady,
  input  logic [SEL_W-1:0]          Sel,
  output logic [WIDTH-1:0]          Out,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [SEL_W-1:0]          OutChan
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             grant_vld_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             load_s;
  logic [WIDTH-1:0] grant_data_s;

  // Grant arbitration: fixed select, or the valid channel closest after ptr (modulo CHANNELS).
  always_comb begin
    int best_dist_v;
    int dist_v;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    best_dist_v = CHANNELS;
    dist_v      = 0;
    if (MODE == 0) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (Sel == SEL_W'(i) && InValid[i]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = SEL_W'(i);
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i >= int'(ptr_q)) begin
          dist_v = i - int'(ptr_q);
        end else begin
          dist_v = i + CHANNELS - int'(ptr_q);
        end
        if (InValid[i] && dist_v < best_dist_v) begin
          best_dist_v = dist_v;
          grant_vld_s = 1'b1;
          grant_idx_s = SEL_W'(i);
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Consume handshake; held low during reset because reset discards any concurrent transfer.
  always_comb begin
    load_s  = rst & (~out_valid_q | OutReady);
    InReady = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      InReady[i] = load_s & grant_vld_s & (grant_idx_s == SEL_W'(i));
    end
  end

  // Data path mux for the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx_s == SEL_W'(i)) begin
        grant_data_s = In[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Next-state logic for the output register and round-robin pointer.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      if (grant_vld_s) begin
        out_d       = grant_data_s;
        out_chan_d  = grant_idx_s;
        out_valid_d = 1'b1;
        // Pointer wraps at CHANNELS, not at 2^SEL_W.
        if (MODE == 1) begin
          if (grant_idx_s == SEL_W'(CHANNELS - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_idx_s + SEL_W'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Out      = out_q;
  assign OutValid = out_valid_q;
  assign OutChan  = out_chan_q;

endmodule
